// File: rtl/chunk_serial_adder_pkg.sv
// Shared types and helpers for the chunk-serial adder.
// Provides the FSM state type and a constant log2 function used to size
// the chunk counter in each instance.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Ceiling log2 for elaboration-time sizing; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/chunk_fadd.sv
// Combinational CHUNK-bit adder slice.
// Besides sum and carry-out it reports the carry into its MSB so the caller
// can derive signed overflow when this slice holds the operand MSB.
module chunk_fadd #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [CHUNK:0] total_s;

   // Add the slice; the carry into the MSB is recovered from the MSB sum bit.
   always_comb begin
      total_s = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
      sum     = total_s[CHUNK-1:0];
      cout    = total_s[CHUNK];
      c_msb   = a[CHUNK-1] ^ b[CHUNK-1] ^ total_s[CHUNK-1];
   end

endmodule

// File: rtl/chunk_serial_adder.sv
// Multi-cycle ripple adder: adds two WIDTH-bit operands CHUNK bits per
// clock with the inter-chunk carry held in a register. Valid/ready
// handshakes on the operand and result sides.
// Optional feature: define SUB_MODE_EN to add the 'sub' port, which makes
// the block compute a-b (B inverted at accept, initial carry forced to 1).
module chunk_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SUB_MODE_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
   localparam int NCHUNK     = WIDTH / SAFE_CHUNK;
   localparam int CNT_W      = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

   if ((CHUNK < 1) || ((WIDTH % SAFE_CHUNK) != 0)) begin : g_param_check
      $error("chunk_serial_adder: WIDTH must be a positive multiple of CHUNK");
   end

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;

   int                 base_s;
   logic [CHUNK-1:0]   a_slice_s;
   logic [CHUNK-1:0]   b_slice_s;
   logic [CHUNK-1:0]   fa_sum_s;
   logic               fa_cout_s;
   logic               fa_cmsb_s;

   // Select the operand slices addressed by the chunk counter.
   always_comb begin
      base_s    = int'(cnt_q) * CHUNK;
      a_slice_s = a_q[base_s +: CHUNK];
      b_slice_s = b_q[base_s +: CHUNK];
   end

   chunk_fadd #(
      .CHUNK (CHUNK)
   ) u_fadd (
      .a     (a_slice_s),
      .b     (b_slice_s),
      .cin   (carry_q),
      .sum   (fa_sum_s),
      .cout  (fa_cout_s),
      .c_msb (fa_cmsb_s)
   );

   // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d = a;
`ifdef SUB_MODE_EN
               if (sub) begin
                  b_d     = ~b;
                  carry_d = 1'b1;
               end else begin
                  b_d     = b;
                  carry_d = cin;
               end
`else
               b_d     = b;
               carry_d = cin;
`endif
               cnt_d       = '0;
               sum_d       = '0;
               cout_d      = 1'b0;
               ovf_d       = 1'b0;
               in_ready_d  = 1'b0;
               out_valid_d = 1'b0;
               state_d     = RUN;
            end else begin
               in_ready_d = 1'b1;
               state_d    = IDLE;
            end
         end

         RUN: begin
            sum_d[base_s +: CHUNK] = fa_sum_s;
            carry_d                = fa_cout_s;
            if (cnt_q == CNT_LAST) begin
               cout_d      = fa_cout_s;
               ovf_d       = fa_cout_s ^ fa_cmsb_s;
               cnt_d       = '0;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               state_d = RUN;
            end
         end

         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end else begin
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end

         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            cnt_d       = '0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Self-checking bench for chunk_serial_adder (WIDTH=8).
// Directed tests run on a CHUNK=2 instance; a sweep drives CHUNK=1/2/8
// instances in lockstep against a golden a+b+cin model.
module tb_chunk_serial_adder;

   typedef struct packed {
      logic [7:0] s;
      logic       co;
      logic       ov;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;

   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] a, b, sum;
   logic       cin, sub, cout, ovf;

   logic       sw_in_valid;
   logic [7:0] sw_a, sw_b;
   logic       sw_cin;
   logic [2:0] sw_ir, sw_ov, sw_or, sw_co, sw_of;
   logic [7:0] sw_sum [3];

   int         errors = 0;
   int         checks = 0;
   exp_t       q_main[$];
   exp_t       sw_exp[$];
   int         sw_rd[3];

   always #5 clk = ~clk;

   chunk_serial_adder #(.WIDTH(8), .CHUNK(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
`ifdef SUB_MODE_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   chunk_serial_adder #(.WIDTH(8), .CHUNK(1)) dut_c1 (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_ir[0]),
      .a(sw_a), .b(sw_b), .cin(sw_cin),
`ifdef SUB_MODE_EN
      .sub(1'b0),
`endif
      .out_valid(sw_ov[0]), .out_ready(sw_or[0]),
      .sum(sw_sum[0]), .cout(sw_co[0]), .ovf(sw_of[0])
   );

   chunk_serial_adder #(.WIDTH(8), .CHUNK(2)) dut_c2 (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_ir[1]),
      .a(sw_a), .b(sw_b), .cin(sw_cin),
`ifdef SUB_MODE_EN
      .sub(1'b0),
`endif
      .out_valid(sw_ov[1]), .out_ready(sw_or[1]),
      .sum(sw_sum[1]), .cout(sw_co[1]), .ovf(sw_of[1])
   );

   chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) dut_c8 (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_ir[2]),
      .a(sw_a), .b(sw_b), .cin(sw_cin),
`ifdef SUB_MODE_EN
      .sub(1'b0),
`endif
      .out_valid(sw_ov[2]), .out_ready(sw_or[2]),
      .sum(sw_sum[2]), .cout(sw_co[2]), .ovf(sw_of[2])
   );

   // Golden model: (sub) inverts B and forces carry-in to 1.
   function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb,
                                  input logic mc, input logic ms);
      exp_t       r;
      logic [7:0] bb;
      logic       c;
      logic [8:0] t;
      bb   = ms ? ~mb : mb;
      c    = ms ? 1'b1 : mc;
      t    = {1'b0, ma} + {1'b0, bb} + {8'd0, c};
      r.s  = t[7:0];
      r.co = t[8];
      r.ov = (ma[7] == bb[7]) && (t[7] != ma[7]);
      return r;
   endfunction

   // Present one operand set to the main DUT; optionally expect a result.
   task automatic accept(input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tc, input logic ts, input bit keep);
      int n;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_wait: in_ready=%b expected 1", in_ready);
      end
      a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
      if (keep) q_main.push_back(model(ta, tb_v, tc, ts));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait for a result, optionally hold it off, then compare and hand it off.
   task automatic collect(input int hold);
      int   n;
      exp_t e;
      n = 0;
      out_ready = 1'b0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL result_timeout: out_valid=%b expected 1", out_valid);
      end
      checks++;
      if (q_main.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got result with no expectation (0 of 1)");
         e = '0;
      end else begin
         e = q_main.pop_front();
      end
      for (int i = 0; i < hold; i++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e.s ||
             cout !== e.co || ovf !== e.ov) begin
            errors++;
            $display("FAIL hold_stable: cyc=%0d ov=%b ir=%b sum=%h co=%b ovf=%b expected 1 0 %h %b %b",
                     i, out_valid, in_ready, sum, cout, ovf, e.s, e.co, e.ov);
         end
         @(negedge clk);
      end
      checks++;
      if (sum !== e.s) begin
         errors++;
         $display("FAIL sum: got %h expected %h", sum, e.s);
      end
      checks++;
      if (cout !== e.co) begin
         errors++;
         $display("FAIL cout: got %b expected %b", cout, e.co);
      end
      checks++;
      if (ovf !== e.ov) begin
         errors++;
         $display("FAIL ovf: got %b expected %b", ovf, e.ov);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL handoff: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 ||
          cout !== 1'b0 || ovf !== 1'b0 || sw_ov !== 3'b000 || sw_ir !== 3'b111) begin
         errors++;
         $display("FAIL reset: ir=%b ov=%b sum=%h co=%b ovf=%b sw_ov=%b sw_ir=%b expected 1 0 00 0 0 000 111",
                  in_ready, out_valid, sum, cout, ovf, sw_ov, sw_ir);
      end
   endtask

   task automatic test_basic;
      accept(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== (i == 4)) begin
            errors++;
            $display("FAIL latency: cycle %0d out_valid=%b expected %b", i, out_valid, (i == 4));
         end
      end
      collect(0);
   endtask

   task automatic test_wrap;
      accept(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
      collect(0);
      accept(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
      collect(0);
      accept(8'h80, 8'h80, 1'b1, 1'b0, 1'b1);
      collect(0);
   endtask

   task automatic test_backpressure;
      accept(8'hA7, 8'h3C, 1'b1, 1'b0, 1'b1);
      collect(5);
   endtask

   task automatic test_operand_change;
      accept(8'h3C, 8'hA5, 1'b1, 1'b0, 1'b1);
      repeat (4) begin
         a   = 8'($urandom);
         b   = 8'($urandom);
         cin = 1'($urandom);
         sub = 1'($urandom);
         @(negedge clk);
      end
      collect(0);
   endtask

   task automatic test_reset_mid_run;
      bit seen;
      accept(8'h55, 8'hAA, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || sum !== 8'h00 || in_ready !== 1'b1 ||
          cout !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL mid_run_reset: ov=%b sum=%h ir=%b co=%b ovf=%b expected 0 00 1 0 0",
                  out_valid, sum, in_ready, cout, ovf);
      end
      seen = 1'b0;
      out_ready = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen = 1'b1;
      end
      out_ready = 1'b0;
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL aborted_result: out_valid seen=%b expected 0", seen);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++) begin
         accept(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b1);
         collect(i % 2);
      end
   endtask

`ifdef SUB_MODE_EN
   task automatic test_sub;
      accept(8'h05, 8'h07, 1'b0, 1'b1, 1'b1);
      collect(0);
      accept(8'h80, 8'h01, 1'b1, 1'b1, 1'b1);
      collect(0);
      accept(8'h10, 8'h03, 1'b1, 1'b1, 1'b1);
      collect(0);
   endtask
`endif

   task automatic test_sweep;
      int   n;
      bit   r;
      bit   done;
      exp_t e;
      for (int op = 0; op < 30; op++) begin
         sw_or = 3'b000;
         n = 0;
         @(negedge clk);
         while (sw_ir !== 3'b111 && n < 60) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (sw_ir !== 3'b111) begin
            errors++;
            $display("FAIL sweep_ready: op=%0d in_ready=%b expected 111", op, sw_ir);
         end
         sw_a   = (op == 0) ? 8'hFF : 8'($urandom);
         sw_b   = (op == 0) ? 8'h01 : 8'($urandom);
         sw_cin = (op == 0) ? 1'b0  : 1'($urandom);
         sw_in_valid = 1'b1;
         sw_exp.push_back(model(sw_a, sw_b, sw_cin, 1'b0));
         @(negedge clk);
         sw_in_valid = 1'b0;
         n = 0;
         done = 1'b0;
         while (!done && n < 60) begin
            for (int k = 0; k < 3; k++) begin
               r = 1'($urandom);
               if (sw_ov[k] === 1'b1 && r) begin
                  checks++;
                  if (sw_rd[k] >= sw_exp.size()) begin
                     errors++;
                     $display("FAIL sweep_extra: dut %0d produced result %0d of %0d",
                              k, sw_rd[k] + 1, sw_exp.size());
                  end else begin
                     e = sw_exp[sw_rd[k]];
                     sw_rd[k]++;
                     if (sw_sum[k] !== e.s || sw_co[k] !== e.co || sw_of[k] !== e.ov) begin
                        errors++;
                        $display("FAIL sweep_result: dut %0d op %0d sum=%h co=%b ovf=%b expected %h %b %b",
                                 k, op, sw_sum[k], sw_co[k], sw_of[k], e.s, e.co, e.ov);
                     end
                  end
               end
               sw_or[k] = r;
            end
            @(negedge clk);
            n++;
            done = (sw_rd[0] == sw_exp.size()) && (sw_rd[1] == sw_exp.size()) &&
                   (sw_rd[2] == sw_exp.size());
         end
         checks++;
         if (!done) begin
            errors++;
            $display("FAIL sweep_timeout: op=%0d results %0d/%0d/%0d of %0d",
                     op, sw_rd[0], sw_rd[1], sw_rd[2], sw_exp.size());
         end
      end
      sw_or = 3'b000;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0;
      a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
      sw_in_valid = 1'b0; sw_or = 3'b000;
      sw_a = 8'h00; sw_b = 8'h00; sw_cin = 1'b0;
      for (int k = 0; k < 3; k++) sw_rd[k] = 0;

      test_reset;
      test_basic;
      test_wrap;
      test_backpressure;
      test_operand_change;
      test_reset_mid_run;
      test_back_to_back;
`ifdef SUB_MODE_EN
      test_sub;
`endif
      test_sweep;

      checks++;
      if (q_main.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left: %0d results never produced, expected 0", q_main.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
